mem_burst_master: RTL and testbench

- Initiator-side engine for the single-port synchronous memory bus (addr, wr_en, rd_en, wdata, rdata).
- Accepts burst commands over a valid/ready interface and generates write bursts (incrementing data pattern) or read bursts on the memory port.
- Returns read data through a buffered valid/ready response stream with backpressure.
- Sits between test/control logic and the memory, replacing direct bus driving.

---
 rtl/mem_master_pkg.sv | 18 +
 rtl/mem_rsp_fifo.sv | 68 ++++++
 rtl/mem_burst_master.sv | 213 +++++++++++++++++++++
 tb/tb_mem_burst_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and default widths for the memory burst master.
package mem_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_LEN_W     = 4;
    localparam int unsigned DEF_RD_LAT    = 1;
    localparam int unsigned DEF_RSP_DEPTH = 4;
    localparam int unsigned ERR_W         = 8;

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; head_c is the
// unregistered read port of the storage array.
module mem_rsp_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_c,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_d;

    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = CNT_W'(count + 1'b1);
            2'b01:   count_d = CNT_W'(count - 1'b1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign head_c = mem_q[rd_ptr];

    overflow_a: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));

endmodule

// File: rtl/mem_burst_master.sv
// Burst engine for the single-port synchronous memory bus: pattern writes,
// credit-limited reads and a buffered response stream.
// Optional read-data checker enabled by defining MEM_BURST_VERIFY_EN.
module mem_burst_master
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned RD_LAT    = DEF_RD_LAT,
    parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              done
`ifdef MEM_BURST_VERIFY_EN
    ,
    output logic [ERR_W-1:0]  err_count
`endif
);

    localparam int unsigned RSP_W  = DATA_W + 1;
    localparam int unsigned FCNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + RD_LAT + 2);

    state_e            state_q;
    state_e            state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [LEN_W-1:0]  beat_q;
    logic [LEN_W-1:0]  beat_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_wr_en_d;
    logic              mem_rd_en_d;
    logic              mem_last_q;
    logic              mem_last_d;
    logic              done_d;
    logic              handshake;

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;

    logic              push;
    logic              pop;
    logic [RSP_W-1:0]  head_c;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  committed;
    logic              credit_ok;

    assign handshake = cmd_valid && cmd_ready;
    assign push      = vld_sr[RD_LAT-1];
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = head_c[DATA_W-1:0];
    assign rsp_last  = head_c[DATA_W];

    // Every outstanding strobe (on the bus or in the latency pipe) owns a FIFO slot.
    always_comb begin
        inflight = CNT_W'(mem_rd_en);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = CNT_W'(inflight + CNT_W'(vld_sr[i]));
        end
        committed = CNT_W'(inflight + CNT_W'(fifo_count));
        credit_ok = (committed < CNT_W'(RSP_DEPTH));
    end

    // Next-state and next-output logic; beat 0 is launched straight from IDLE.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_last_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    len_d       = cmd_len;
                    beat_d      = '0;
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = cmd_wdata;
                    if (cmd_write) begin
                        mem_wr_en_d = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        mem_last_d  = (cmd_len == '0);
                        state_d     = (cmd_len == '0) ? DRAIN : READ;
                    end
                end
            end
            WRITE: begin
                if (beat_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d      = LEN_W'(beat_q + 1'b1);
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = ADDR_W'(mem_addr + 1'b1);
                    mem_wdata_d = DATA_W'(mem_wdata + 1'b1);
                end
            end
            READ: begin
                if (credit_ok) begin
                    beat_d      = LEN_W'(beat_q + 1'b1);
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = ADDR_W'(mem_addr + 1'b1);
                    mem_last_d  = (LEN_W'(beat_q + 1'b1) == len_q);
                    if (mem_last_d) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && pop && rsp_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_q     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_last_q <= 1'b0;
            vld_sr     <= '0;
            last_sr    <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wr_en  <= mem_wr_en_d;
            mem_rd_en  <= mem_rd_en_d;
            mem_last_q <= mem_last_d;
            vld_sr     <= RD_LAT'((vld_sr << 1) | RD_LAT'(mem_rd_en));
            last_sr    <= RD_LAT'((last_sr << 1) | RD_LAT'(mem_last_q));
            done       <= done_d;
            busy       <= (state_d != IDLE);
            cmd_ready  <= (state_d == IDLE);
        end
    end

    mem_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({last_sr[RD_LAT-1], mem_rdata}),
        .pop       (pop),
        .head_c    (head_c),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef MEM_BURST_VERIFY_EN
    logic [DATA_W-1:0] exp_q;

    // Popped read beats are expected to follow the seed pattern of the burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q     <= '0;
            err_count <= '0;
        end else begin
            if (handshake && !cmd_write) begin
                exp_q <= cmd_wdata;
            end else if (pop) begin
                exp_q <= DATA_W'(exp_q + 1'b1);
            end
            if (pop && (rsp_data != exp_q) && (err_count != {ERR_W{1'b1}})) begin
                err_count <= ERR_W'(err_count + 1'b1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a one-cycle-latency memory model.
module tb_mem_burst_master;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       done;
`ifdef MEM_BURST_VERIFY_EN
    logic [7:0] err_count;
`endif

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       poke = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [7:0] poke_data = '0;

    wr_t        wq[$];
    logic [7:0] raq[$];
    logic [8:0] rq[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int last_pop_cyc = -1;
    int done_cyc = -1;

    mem_burst_master dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .done      (done)
`ifdef MEM_BURST_VERIFY_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (poke) mem[poke_addr] <= poke_data;
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus and response monitor: pops expectations as the DUT produces traffic.
    always @(negedge clk) begin
        wr_t        w;
        logic [8:0] e;
        if (reset) begin
            if (mem_wr_en || mem_rd_en)
                check("strobe_excl", 32'(mem_wr_en & mem_rd_en), 32'd0);
            if (mem_wr_en) begin
                if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.a));
                    check("wr_data", 32'(mem_wdata), 32'(w.d));
                end
            end
            if (mem_rd_en) begin
                rd_cnt++;
                if (raq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else check("rd_addr", 32'(mem_addr), 32'(raq.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = rq.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
                    check("rsp_last", 32'(rsp_last), 32'(e[8]));
                end
                if (rsp_last) last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [3:0] l, input logic [7:0] s);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        for (int i = 0; i <= int'(l); i++) begin
            logic [7:0] ad;
            logic [7:0] dd;
            ad = 8'(int'(a) + i);
            dd = 8'(int'(s) + i);
            if (wr) begin
                wq.push_back('{a: ad, d: dd});
                ref_mem[ad] = dd;
            end else begin
                raq.push_back(ad);
                rq.push_back({(i == int'(l)), ref_mem[ad]});
            end
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wdata = s;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int rd0;
        int n;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Write burst: four back-to-back beats, then done with busy low.
        send_cmd(1'b1, 8'h10, 4'd3, 8'hA0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wr_strobe", 32'(mem_wr_en), 32'd1);
            check("wr_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("wr_end_strobe", 32'(mem_wr_en), 32'd0);
        check("wr_done", 32'(done), 32'd1);
        check("wr_idle", 32'({busy, cmd_ready}), 32'b01);
        @(negedge clk);
        check("wr_done_pulse", 32'(done), 32'd0);

        // Read back with the consumer always ready.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 8'h10, 4'd3, 8'hA0);
        wait_done(50);
        check("done_after_last_pop", 32'(done_cyc), 32'(last_pop_cyc + 1));
        check("rd_queue_empty", 32'(rq.size()), 32'd0);

        // Full-length read against a stalled consumer.
        send_cmd(1'b1, 8'h20, 4'd15, 8'h30);
        wait_done(50);
        rsp_ready = 1'b0;
        rd0 = rd_cnt;
        send_cmd(1'b0, 8'h20, 4'd15, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        check("stall_strobes", 32'(rd_cnt - rd0), 32'd4);
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        wait_done(100);
        check("bp_total_strobes", 32'(rd_cnt - rd0), 32'd16);
        check("bp_queue_empty", 32'(rq.size()), 32'd0);

        // Address and data wrap.
        send_cmd(1'b1, 8'hFE, 4'd3, 8'hFF);
        wait_done(50);
        check("wrap_wq_empty", 32'(wq.size()), 32'd0);
        send_cmd(1'b0, 8'hFE, 4'd3, 8'h00);
        wait_done(50);

        // Single-beat read.
        send_cmd(1'b0, 8'h12, 4'd0, 8'h00);
        wait_done(50);

        // Reset in the middle of an eight-beat read.
        send_cmd(1'b1, 8'h40, 4'd7, 8'h70);
        wait_done(50);
        rd0 = rd_cnt;
        send_cmd(1'b0, 8'h40, 4'd7, 8'h00);
        n = 0;
        while ((rd_cnt - rd0) < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_progress", 32'((rd_cnt - rd0) >= 3), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'd0);
        check("midrst_ctrl", 32'({cmd_ready, busy, done}), 32'd0);
        wq.delete();
        raq.delete();
        rq.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        check("midrst_fifo_empty", 32'(rsp_valid), 32'd0);
        send_cmd(1'b0, 8'h40, 4'd7, 8'h00);
        wait_done(50);
        check("midrst_queue_empty", 32'(rq.size()), 32'd0);

`ifdef MEM_BURST_VERIFY_EN
        pulse_reset();
        check("err_after_reset", 32'(err_count), 32'd0);
        poke_addr = 8'h11;
        poke_data = 8'h00;
        poke = 1'b1;
        ref_mem[8'h11] = 8'h00;
        @(posedge clk); #1;
        poke = 1'b0;
        send_cmd(1'b0, 8'h10, 4'd3, 8'hA0);
        wait_done(50);
        check("err_one", 32'(err_count), 32'd1);
        for (int r = 0; r < 299; r++) begin
            send_cmd(1'b0, 8'h10, 4'd3, 8'hA0);
            wait_done(50);
        end
        check("err_saturate", 32'(err_count), 32'd255);
`endif

        check("final_wq", 32'(wq.size()), 32'd0);
        check("final_raq", 32'(raq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
